// File: rtl/wsn_channel_if.sv
// Signal bundle between the two-node bench and one direction of the RF channel emulator.
`timescale 1ns/1ps
interface wsn_channel_if #(
    parameter int DELAY_W = 6,
    parameter int CNT_W   = 32
);
    logic               en;
    logic               tx_in;
    logic               rx_out;
    logic [DELAY_W-1:0] delay;
    logic [15:0]        ber_thresh;
    logic [3:0]         burst_len;
    logic               clr;
    logic [CNT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   err_cnt;
    logic               burst_active;

    modport master (
        output en, tx_in, delay, ber_thresh, burst_len, clr,
        input  rx_out, bit_cnt, err_cnt, burst_active
    );

    modport slave (
        input  en, tx_in, delay, ber_thresh, burst_len, clr,
        output rx_out, bit_cnt, err_cnt, burst_active
    );
endinterface

// File: rtl/wsn_channel.sv
// One-bit RF channel emulator: programmable delay line plus LFSR-driven single/burst bit errors,
// with saturating statistics of transported and corrupted bits.
`timescale 1ns/1ps
module wsn_channel #(
    parameter int          DELAY_W = 6,
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int          CNT_W   = 32
) (
    input  logic         clk,
    input  logic         reset,
    wsn_channel_if.slave ch
);
    localparam int          DEPTH     = 1 << DELAY_W;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    logic [DEPTH-1:0]   r_dline;
    logic [DELAY_W-1:0] r_wptr;
    logic [15:0]        r_lfsr;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_bcnt;
    logic [3:0]         w_bcnt_nxt;
    logic               r_rx_p1;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [CNT_W-1:0]   r_err_cnt;

    logic [DELAY_W-1:0] w_rd_idx;
    logic               w_dly_bit_p0;
    logic               w_trig;
    logic               w_flip;
    logic [15:0]        w_lfsr_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_MASK : 16'h0000);
    endfunction

    // Stage p0: delay-line read, trigger decision and burst control
    assign w_rd_idx     = r_wptr - ch.delay;
    assign w_dly_bit_p0 = (ch.delay == '0) ? ch.tx_in : r_dline[w_rd_idx];
    assign w_trig       = ch.en & (r_lfsr < ch.ber_thresh);
    assign w_lfsr_nxt   = lfsr_step(r_lfsr);

    // The line records even while the link is down so re-enabling replays real history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dline <= '0;
            r_wptr  <= '0;
        end else begin
            r_dline[r_wptr] <= ch.tx_in;
            r_wptr          <= r_wptr + DELAY_W'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bcnt_nxt  = r_bcnt;
        w_flip      = 1'b0;
        if (ch.en) begin
            case (r_state)
                S_IDLE: begin
                    if (w_trig) begin
                        w_flip     = 1'b1;
                        w_bcnt_nxt = ch.burst_len;
                        if (ch.burst_len != 4'd0) begin
                            w_state_nxt = S_BURST;
                        end
                    end
                end
                S_BURST: begin
                    w_flip     = 1'b1;
                    w_bcnt_nxt = r_bcnt - 4'd1;
                    if (r_bcnt == 4'd1) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_bcnt  <= 4'd0;
            r_lfsr  <= SEED;
        end else begin
            r_state <= w_state_nxt;
            r_bcnt  <= w_bcnt_nxt;
            if (ch.en) begin
                r_lfsr <= w_lfsr_nxt;
            end
        end
    end

    // Stage p1: registered output and statistics
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_p1   <= 1'b0;
            r_bit_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            r_rx_p1 <= ch.en & (w_dly_bit_p0 ^ w_flip);
            if (ch.clr) begin
                r_bit_cnt <= '0;
                r_err_cnt <= '0;
            end else begin
                if (ch.en) begin
                    r_bit_cnt <= sat_inc(r_bit_cnt);
                end
                if (w_flip) begin
                    r_err_cnt <= sat_inc(r_err_cnt);
                end
            end
        end
    end

    assign ch.rx_out       = r_rx_p1;
    assign ch.bit_cnt      = r_bit_cnt;
    assign ch.err_cnt      = r_err_cnt;
    assign ch.burst_active = (r_state == S_BURST);
endmodule

// File: tb/tb_wsn_channel.sv
// Scoreboard bench for wsn_channel: a full-width instance plus a 4-bit-counter instance on shared stimulus.
`timescale 1ns/1ps
module tb_wsn_channel;
    localparam int          DW   = 6;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    wsn_channel_if #(.DELAY_W(DW), .CNT_W(32)) ifm ();
    wsn_channel_if #(.DELAY_W(DW), .CNT_W(4))  ifs ();

    assign ifs.en         = ifm.en;
    assign ifs.tx_in      = ifm.tx_in;
    assign ifs.delay      = ifm.delay;
    assign ifs.ber_thresh = ifm.ber_thresh;
    assign ifs.burst_len  = ifm.burst_len;
    assign ifs.clr        = ifm.clr;

    wsn_channel #(.DELAY_W(DW), .SEED(SEED), .CNT_W(32)) u_dut (
        .clk   (clk),
        .reset (rst_n),
        .ch    (ifm)
    );

    wsn_channel #(.DELAY_W(DW), .SEED(SEED), .CNT_W(4)) u_dut_sat (
        .clk   (clk),
        .reset (rst_n),
        .ch    (ifs)
    );

    typedef struct {
        logic        rx;
        logic [31:0] bc;
        logic [31:0] ec;
        logic        ba;
        logic [3:0]  sbc;
        logic [3:0]  sec;
    } exp_t;

    exp_t        sb_q[$];
    logic        hist[$];
    logic [15:0] m_lfsr;
    int          m_rem;
    logic [31:0] m_bc, m_ec;
    logic [3:0]  m_sbc, m_sec;
    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc    = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        sb_q.delete();
        m_lfsr = SEED;
        m_rem  = 0;
        m_bc   = '0;
        m_ec   = '0;
        m_sbc  = '0;
        m_sec  = '0;
    endtask

    task automatic step(input logic t_en, input logic t_tx);
        exp_t e;
        logic dbit, flip;
        int   idx;
        ifm.en    = t_en;
        ifm.tx_in = t_tx;
        hist.push_back(t_tx);
        idx  = hist.size() - 1 - int'(ifm.delay);
        dbit = (idx >= 0) ? hist[idx] : 1'b0;
        flip = 1'b0;
        if (t_en) begin
            if (m_rem > 0) begin
                flip = 1'b1;
                m_rem--;
            end else if (m_lfsr < ifm.ber_thresh) begin
                flip  = 1'b1;
                m_rem = int'(ifm.burst_len);
            end
            m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
        end
        if (ifm.clr) begin
            m_bc = '0; m_ec = '0; m_sbc = '0; m_sec = '0;
        end else begin
            if (t_en) begin
                if (m_bc != 32'hFFFF_FFFF) m_bc++;
                if (m_sbc != 4'hF) m_sbc++;
            end
            if (flip) begin
                if (m_ec != 32'hFFFF_FFFF) m_ec++;
                if (m_sec != 4'hF) m_sec++;
            end
        end
        e.rx  = t_en & (dbit ^ flip);
        e.bc  = m_bc;
        e.ec  = m_ec;
        e.ba  = (m_rem != 0);
        e.sbc = m_sbc;
        e.sec = m_sec;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        e = sb_q.pop_front();
        chk("rx_out", ifm.rx_out, e.rx);
        chk("bit_cnt", ifm.bit_cnt, e.bc);
        chk("err_cnt", ifm.err_cnt, e.ec);
        chk("burst_active", ifm.burst_active, e.ba);
        chk("sat_bit_cnt", ifs.bit_cnt, e.sbc);
        chk("sat_err_cnt", ifs.err_cnt, e.sec);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_rx_out", ifm.rx_out, 0);
        chk("rst_bit_cnt", ifm.bit_cnt, 0);
        chk("rst_err_cnt", ifm.err_cnt, 0);
        chk("rst_burst", ifm.burst_active, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] snap_bc, snap_ec;
        logic        txs[200];
        int          run;
        logic        found;

        ifm.en = 1'b0; ifm.tx_in = 1'b0; ifm.delay = '0;
        ifm.ber_thresh = 16'h0000; ifm.burst_len = 4'd0; ifm.clr = 1'b0;
        #2;
        do_reset();

        // Test 1: single pulse through zero delay, no errors
        for (int i = 0; i < 20; i++) begin
            step(1'b1, (i == 10));
            chk("t1_pulse", ifm.rx_out, (i == 10));
        end
        chk("t1_bit_cnt20", ifm.bit_cnt, 20);
        chk("t1_err_cnt0", ifm.err_cnt, 0);
        chk("t1_sat_hold", ifs.bit_cnt, 4'hF);

        ifm.clr = 1'b1;
        step(1'b1, 1'b0);
        ifm.clr = 1'b0;
        chk("clr_prio", ifm.bit_cnt, 0);
        chk("clr_prio_sat", ifs.bit_cnt, 0);

        // Test 2: maximum delay with random data
        do_reset();
        ifm.delay = 6'd63;
        for (int i = 0; i < 200; i++) begin
            txs[i] = 1'($urandom_range(0, 1));
            step(1'b1, txs[i]);
            chk("t2_delay63", ifm.rx_out, (i >= 63) ? txs[i-63] : 1'b0);
        end
        for (int i = 0; i < 20; i++) step(1'b1, 1'($urandom_range(0, 1)));
        ifm.delay = 6'd5;
        for (int i = 0; i < 20; i++) step(1'b1, 1'($urandom_range(0, 1)));
        ifm.delay = 6'd0;
        for (int i = 0; i < 10; i++) step(1'b1, 1'($urandom_range(0, 1)));

        // Test 3: every cycle triggers except lfsr==FFFF
        snap_ec = ifm.err_cnt;
        ifm.ber_thresh = 16'hFFFF;
        ifm.burst_len  = 4'd0;
        for (int i = 0; i < 100; i++) step(1'b1, 1'b0);
        chk("t3_err_total", ifm.err_cnt, m_ec);

        // Test 4: burst length 3
        ifm.ber_thresh = 16'h0800;
        ifm.burst_len  = 4'd3;
        run = 0;
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 1'($urandom_range(0, 1)));
            if (ifm.burst_active) run++;
            else begin
                if (run != 0) chk("t4_burst_run", run, 3);
                run = 0;
            end
        end

        // Test 5: link drop in the middle of a long burst
        ifm.ber_thresh = 16'h2000;
        ifm.burst_len  = 4'd15;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            step(1'b1, 1'($urandom_range(0, 1)));
            if (m_rem == 8) found = 1'b1;
        end
        chk("t5_burst_found", found, 1);
        snap_bc = ifm.bit_cnt;
        snap_ec = ifm.err_cnt;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)));
            chk("t5_gap_rx", ifm.rx_out, 0);
        end
        chk("t5_bc_frozen", ifm.bit_cnt, snap_bc);
        chk("t5_ec_frozen", ifm.err_cnt, snap_ec);
        chk("t5_burst_held", ifm.burst_active, found);
        for (int i = 0; i < 30; i++) step(1'b1, 1'($urandom_range(0, 1)));

        // Test 6: saturation, clear priority, asynchronous reset mid-stream
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
        chk("t6_sat_bc", ifs.bit_cnt, 4'hF);
        ifm.clr = 1'b1;
        step(1'b1, 1'b1);
        ifm.clr = 1'b0;
        chk("t6_clr_bc", ifm.bit_cnt, 0);
        chk("t6_clr_sat", ifs.bit_cnt, 0);
        ifm.ber_thresh = 16'hFFFF;
        ifm.burst_len  = 4'd2;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_arst_rx", ifm.rx_out, 0);
        chk("t6_arst_bc", ifm.bit_cnt, 0);
        chk("t6_arst_ec", ifm.err_cnt, 0);
        chk("t6_arst_ba", ifm.burst_active, 0);
        chk("t6_arst_sat", ifs.bit_cnt, 0);
        do_reset();
        ifm.ber_thresh = 16'h0800;
        ifm.burst_len  = 4'd2;
        for (int i = 0; i < 60; i++) step(1'b1, 1'($urandom_range(0, 1)));

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wsn_channel.md
Name: wsn_channel

Overview:
- One-bit RF channel emulator placed between antena_out of one SoC and antena_in of the other in the two-node system bench.
- Delays the transmitted bit stream by a programmable number of cycles and injects bit errors, either single or in bursts, from a 16-bit LFSR.
- Counts transported and corrupted bits so the bench can check link robustness against firmware-reported results.
- One instance per direction.

Parameters:
- DELAY_W, 6: width of delay input; delay line depth is 2**DELAY_W bits.
- SEED, 16'hACE1: LFSR reset value; must be nonzero.
- CNT_W, 32: width of statistics counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (reset=0 resets the block).
- en  in  1  channel enable; 0 = link down.
- tx_in  in  1  bit from transmitting node antena_out.
- rx_out  out  1  bit to receiving node antena_in; idle level 0.
- delay  in  DELAY_W  propagation delay in cycles, beyond the 1-cycle register.
- ber_thresh  in  16  error threshold; a trigger fires when lfsr < ber_thresh (unsigned).
- burst_len  in  4  extra consecutive bits flipped after a trigger.
- clr  in  1  synchronous clear of the statistics counters.
- bit_cnt  out  CNT_W  enabled cycles seen.
- err_cnt  out  CNT_W  bits flipped.
- burst_active  out  1  high while a burst is extending.

Behaviour:
- Reset values:
  - rx_out=0, bit_cnt=0, err_cnt=0, burst_active=0.
  - All delay-line bits 0, write pointer 0.
  - lfsr=SEED, burst counter 0.
- Delay line:
  - Circular buffer of 2**DELAY_W bits. Every cycle, including en=0, tx_in is written at wptr and wptr increments modulo 2**DELAY_W.
  - Read index = (wptr - delay) mod 2**DELAY_W, using the pre-increment wptr.
  - With delay=0 the read returns the bit being written this cycle (write-through bypass).
  - rx_out is registered: tx_in at cycle t appears on rx_out at cycle t+delay+1.
- Delay change mid-stream: takes effect the next cycle. Bits may be skipped or repeated. No other side effects.
- LFSR:
  - Galois, 16-bit, polynomial x^16+x^14+x^13+x^11+1, mask 16'hB400, shift right.
  - Advances once per cycle only when en=1. Never reaches 0.
- Trigger: trig = en & (lfsr < ber_thresh), using the current (pre-advance) lfsr value.
  - ber_thresh=0: no errors ever.
  - ber_thresh=16'hFFFF: trigger on every cycle except when lfsr=16'hFFFF.
- Burst state machine:
  - IDLE: if trig, flip the current bit, load burst counter with burst_len, go to BURST if burst_len!=0.
  - BURST: flip the current bit, decrement the counter, return to IDLE when the counter reaches 1.
  - Triggers are ignored in BURST.
  - burst_active=1 exactly in BURST.
  - A trigger therefore flips 1+burst_len consecutive bits.
- Output: rx_out <= en ? (delayed_bit ^ flip) : 0.
- en deasserted:
  - rx_out=0 from the next cycle.
  - LFSR, counters and burst state are frozen; the delay line keeps recording.
  - On re-enable, the burst resumes where it stopped.
- Counters:
  - bit_cnt increments each en=1 cycle.
  - err_cnt increments on each flipped bit.
  - Both saturate at all-ones.
  - clr clears both; clr has priority over a same-cycle increment, giving 0.
  - clr does not affect the LFSR, burst state or delay line.
- Reset asserted mid-operation: all state returns to reset values immediately, asynchronously. The stream restarts from SEED after reset is released.

Test Plan:
1. Reset, en=1, delay=0, ber_thresh=0, drive tx_in pulse at cycle 10 -> rx_out high at cycle 11 only; err_cnt stays 0; bit_cnt=20 after 20 enabled cycles.
2. delay=63, pseudo-random tx_in for 200 cycles, ber_thresh=0 -> rx_out[t]=tx_in[t-64] for all t>=64; rx_out=0 for the first 64 cycles.
3. ber_thresh=16'hFFFF, burst_len=0, 100 cycles, tx_in=0 -> rx_out is the 1-cycle-delayed inversion, with err_cnt=100 unless lfsr=16'hFFFF occurred (cross-check with bench LFSR model).
4. ber_thresh=16'h0800, burst_len=3 -> every error run on rx_out is exactly 4 bits long (or merges at en edges); err_cnt matches the reference model bit for bit; burst_active high for 3 cycles per run.
5. en dropped for 10 cycles mid-burst, then restored -> rx_out=0 during the gap; counters and LFSR unchanged across the gap; remaining burst bits are flipped after re-enable.
6. Force bit_cnt to 32'hFFFFFFFE via counter preload hook or CNT_W=4 build, run 5 cycles -> counter holds all-ones. Assert clr with an increment in the same cycle -> counter reads 0. Assert reset low mid-stream -> rx_out=0 and counters=0 in the same cycle.
